// File: rtl/vc_scheduler.sv
// Weighted round-robin drain of the VC0/VC1 FIFOs into the D0/D1 FIFOs.
// Each head word is routed by its destination bit; pops are gated by the target's almost-full.
module vc_scheduler #(
   parameter int DATA_WIDTH   = 6,
   parameter int WEIGHT_WIDTH = 4,
   parameter int DEST_BIT     = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    init,
   input  logic [WEIGHT_WIDTH-1:0] weight_VC0,
   input  logic [WEIGHT_WIDTH-1:0] weight_VC1,
   input  logic                    empty_fifo_VC0,
   input  logic                    empty_fifo_VC1,
   input  logic [DATA_WIDTH-1:0]   data_out_VC0,
   input  logic [DATA_WIDTH-1:0]   data_out_VC1,
   input  logic                    almost_full_D0,
   input  logic                    almost_full_D1,
   output logic                    pop_VC0_fifo,
   output logic                    pop_VC1_fifo,
   output logic                    push_D0,
   output logic                    push_D1,
   output logic [DATA_WIDTH-1:0]   data_to_D,
   output logic [1:0]              sched_state,
   output logic [7:0]              fwd_count_VC0,
   output logic [7:0]              fwd_count_VC1
);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] SERVE_VC0 = 2'd1;
   localparam logic [1:0] SERVE_VC1 = 2'd2;

   localparam logic [WEIGHT_WIDTH-1:0] W_ONE = WEIGHT_WIDTH'(1);

   logic [1:0]              state_q, state_d;
   logic [WEIGHT_WIDTH-1:0] burst_q, burst_d;
   logic [WEIGHT_WIDTH-1:0] w0_q, w1_q;
   logic                    push_d0_q, push_d1_q;
   logic [DATA_WIDTH-1:0]   data_q;
   logic [7:0]              fwd0_q, fwd1_q;

   logic elig0, elig1;
   logic dest0, dest1;
   logic pop0, pop1;
   logic last0, last1;

   assign dest0 = data_out_VC0[DEST_BIT];
   assign dest1 = data_out_VC1[DEST_BIT];
   assign elig0 = !empty_fifo_VC0 && !(dest0 ? almost_full_D1 : almost_full_D0) && !init;
   assign elig1 = !empty_fifo_VC1 && !(dest1 ? almost_full_D1 : almost_full_D0) && !init;
   assign last0 = (burst_q == (w0_q - W_ONE));
   assign last1 = (burst_q == (w1_q - W_ONE));

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         burst_q <= '0;
      end else begin
         state_q <= state_d;
         burst_q <= burst_d;
      end
   end

   // Next-state logic; burst_cnt restarts on every turn change
   always_comb begin
      state_d = state_q;
      burst_d = burst_q;
      if (init) begin
         state_d = IDLE;
         burst_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               burst_d = '0;
               if (elig0)      state_d = SERVE_VC0;
               else if (elig1) state_d = SERVE_VC1;
            end
            SERVE_VC0: begin
               if (elig0) begin
                  if (last0) begin
                     burst_d = '0;
                     if (elig1) state_d = SERVE_VC1;
                  end else begin
                     burst_d = burst_q + W_ONE;
                  end
               end else begin
                  burst_d = '0;
                  state_d = elig1 ? SERVE_VC1 : IDLE;
               end
            end
            SERVE_VC1: begin
               if (elig1) begin
                  if (last1) begin
                     burst_d = '0;
                     if (elig0) state_d = SERVE_VC0;
                  end else begin
                     burst_d = burst_q + W_ONE;
                  end
               end else begin
                  burst_d = '0;
                  state_d = elig0 ? SERVE_VC0 : IDLE;
               end
            end
            default: begin
               state_d = IDLE;
               burst_d = '0;
            end
         endcase
      end
   end

   // Output logic: pops are combinational so the FIFO advances on the same edge
   always_comb begin
      pop0 = 1'b0;
      pop1 = 1'b0;
      case (state_q)
         SERVE_VC0: pop0 = elig0;
         SERVE_VC1: pop1 = elig1;
         default: begin
            pop0 = 1'b0;
            pop1 = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w0_q <= W_ONE;
         w1_q <= W_ONE;
      end else if (init) begin
         w0_q <= (weight_VC0 == '0) ? W_ONE : weight_VC0;
         w1_q <= (weight_VC1 == '0) ? W_ONE : weight_VC1;
      end
   end

   // One-cycle datapath; a word popped just before init still lands in its D FIFO
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         push_d0_q <= 1'b0;
         push_d1_q <= 1'b0;
         data_q    <= '0;
         fwd0_q    <= '0;
         fwd1_q    <= '0;
      end else begin
         push_d0_q <= (pop0 && !dest0) || (pop1 && !dest1);
         push_d1_q <= (pop0 && dest0) || (pop1 && dest1);
         if (pop0) begin
            data_q <= data_out_VC0;
            fwd0_q <= fwd0_q + 8'd1;
         end else if (pop1) begin
            data_q <= data_out_VC1;
            fwd1_q <= fwd1_q + 8'd1;
         end
      end
   end

   assign pop_VC0_fifo  = pop0;
   assign pop_VC1_fifo  = pop1;
   assign push_D0       = push_d0_q;
   assign push_D1       = push_d1_q;
   assign data_to_D     = data_q;
   assign sched_state   = state_q;
   assign fwd_count_VC0 = fwd0_q;
   assign fwd_count_VC1 = fwd1_q;

endmodule

// File: tb/tb_vc_scheduler.sv
// Bench for vc_scheduler: queue models of the VC FIFOs feed the DUT, and every pop pushes an
// expected {source, word} entry that must reappear on push_Dx one cycle later.
module tb_vc_scheduler;

   localparam int DW = 6;
   localparam int WW = 4;
   localparam int DB = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          init;
   logic [WW-1:0] weight_VC0, weight_VC1;
   logic          empty_fifo_VC0, empty_fifo_VC1;
   logic [DW-1:0] data_out_VC0, data_out_VC1;
   logic          almost_full_D0, almost_full_D1;
   logic          pop_VC0_fifo, pop_VC1_fifo;
   logic          push_D0, push_D1;
   logic [DW-1:0] data_to_D;
   logic [1:0]    sched_state;
   logic [7:0]    fwd_count_VC0, fwd_count_VC1;

   vc_scheduler #(.DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .DEST_BIT(DB)) dut (
      .clk(clk), .reset(reset), .init(init),
      .weight_VC0(weight_VC0), .weight_VC1(weight_VC1),
      .empty_fifo_VC0(empty_fifo_VC0), .empty_fifo_VC1(empty_fifo_VC1),
      .data_out_VC0(data_out_VC0), .data_out_VC1(data_out_VC1),
      .almost_full_D0(almost_full_D0), .almost_full_D1(almost_full_D1),
      .pop_VC0_fifo(pop_VC0_fifo), .pop_VC1_fifo(pop_VC1_fifo),
      .push_D0(push_D0), .push_D1(push_D1), .data_to_D(data_to_D),
      .sched_state(sched_state),
      .fwd_count_VC0(fwd_count_VC0), .fwd_count_VC1(fwd_count_VC1)
   );

   // Clock / reset
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic          init_r = 1'b0;
   logic [WW-1:0] w0_r = '0, w1_r = '0;
   logic          af0_r = 1'b0, af1_r = 1'b0;

   logic [DW-1:0] vc0_q[$];
   logic [DW-1:0] vc1_q[$];
   logic [DW:0]   exp_q[$];
   int            pop_log[$];
   int            pop_cyc[$];
   logic [7:0]    m_cnt0 = '0, m_cnt1 = '0;

   task automatic clear_model();
      vc0_q.delete(); vc1_q.delete(); exp_q.delete();
      pop_log.delete(); pop_cyc.delete();
      m_cnt0 = '0; m_cnt1 = '0;
   endtask

   task automatic drive_idle();
      init = 1'b0; weight_VC0 = '0; weight_VC1 = '0;
      empty_fifo_VC0 = 1'b1; empty_fifo_VC1 = 1'b1;
      data_out_VC0 = '0; data_out_VC1 = '0;
      almost_full_D0 = 1'b0; almost_full_D1 = 1'b0;
   endtask

   // One cycle: score pushes from the last edge, drive inputs, record this cycle's pops
   task automatic step();
      logic [DW:0]   e;
      logic [DW-1:0] w;
      @(negedge clk);
      cyc++;
      if (push_D0 && push_D1) begin
         checks++; errors++;
         $display("FAIL push_both: push_D0=%b push_D1=%b required one-hot", push_D0, push_D1);
      end
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         w = e[DW-1:0];
         if (e[DW]) m_cnt1++; else m_cnt0++;
         checks++;
         if (push_D0 !== !w[DB] || push_D1 !== w[DB] || data_to_D !== w) begin
            errors++;
            $display("FAIL push_data: cyc %0d got D0=%b D1=%b data=%h required D0=%b D1=%b data=%h",
                     cyc, push_D0, push_D1, data_to_D, !w[DB], w[DB], w);
         end
         checks++;
         if (fwd_count_VC0 !== m_cnt0 || fwd_count_VC1 !== m_cnt1) begin
            errors++;
            $display("FAIL fwd_count: cyc %0d got %0d/%0d required %0d/%0d",
                     cyc, fwd_count_VC0, fwd_count_VC1, m_cnt0, m_cnt1);
         end
      end else if (push_D0 || push_D1) begin
         checks++; errors++;
         $display("FAIL unexpected_push: cyc %0d D0=%b D1=%b data=%h required no push",
                  cyc, push_D0, push_D1, data_to_D);
      end
      init = init_r; weight_VC0 = w0_r; weight_VC1 = w1_r;
      almost_full_D0 = af0_r; almost_full_D1 = af1_r;
      empty_fifo_VC0 = (vc0_q.size() == 0);
      empty_fifo_VC1 = (vc1_q.size() == 0);
      data_out_VC0 = empty_fifo_VC0 ? '0 : vc0_q[0];
      data_out_VC1 = empty_fifo_VC1 ? '0 : vc1_q[0];
      #1;
      if (pop_VC0_fifo && pop_VC1_fifo) begin
         checks++; errors++;
         $display("FAIL pop_both: cyc %0d both pops high required at most one", cyc);
      end else if (pop_VC0_fifo) begin
         exp_q.push_back({1'b0, vc0_q.pop_front()});
         pop_log.push_back(0); pop_cyc.push_back(cyc);
      end else if (pop_VC1_fifo) begin
         exp_q.push_back({1'b1, vc1_q.pop_front()});
         pop_log.push_back(1); pop_cyc.push_back(cyc);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      init_r = 1'b0; af0_r = 1'b0; af1_r = 1'b0;
      clear_model();
      drive_idle();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic load_weights(input logic [WW-1:0] w0, input logic [WW-1:0] w1);
      w0_r = w0; w1_r = w1; init_r = 1'b1;
      step();
      init_r = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((vc0_q.size() != 0 || vc1_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL drain_timeout: %0d/%0d/%0d words left after %0d cycles required 0",
                  vc0_q.size(), vc1_q.size(), exp_q.size(), budget);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clear_model();
      drive_idle();
      #2;
      checks++;
      if (sched_state !== 2'd0 || push_D0 !== 1'b0 || push_D1 !== 1'b0 || data_to_D !== '0 ||
          fwd_count_VC0 !== 8'd0 || fwd_count_VC1 !== 8'd0 || pop_VC0_fifo !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: st=%0d push=%b%b data=%h cnt=%0d/%0d required all 0",
                  sched_state, push_D0, push_D1, data_to_D, fwd_count_VC0, fwd_count_VC1);
      end
      @(negedge clk);
      reset = 1'b0;
      vc0_q = '{6'h03, 6'h05, 6'h07};
      for (int i = 0; i < 8 && pop_log.size() < 2; i++) step();
      checks++;
      if (pop_log.size() != 2) begin
         errors++;
         $display("FAIL reset_setup_pops: got %0d pops required 2", pop_log.size());
      end
      // Assert reset between edges while VC0 pops and the previous word pushes
      reset = 1'b1;
      #1;
      checks++;
      if (pop_VC0_fifo !== 1'b0 || push_D0 !== 1'b0 || push_D1 !== 1'b0 || sched_state !== 2'd0) begin
         errors++;
         $display("FAIL async_reset: pop=%b push=%b%b st=%0d required 0 0 0 0",
                  pop_VC0_fifo, push_D0, push_D1, sched_state);
      end
      checks++;
      if (data_to_D !== '0 || fwd_count_VC0 !== 8'd0) begin
         errors++;
         $display("FAIL async_reset_data: data=%h cnt0=%0d required 0 0", data_to_D, fwd_count_VC0);
      end
      clear_model();
      drive_idle();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_weighted_rr();
      int exp_order[16] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 1, 1, 1};
      int start;
      do_reset();
      load_weights(4'd2, 4'd1);
      pop_log.delete(); pop_cyc.delete();
      for (int i = 0; i < 8; i++) begin
         vc0_q.push_back(DW'(i));
         vc1_q.push_back(DW'(8 + i));
      end
      start = cyc + 1;
      for (int i = 0; i < 20; i++) step();
      checks++;
      if (pop_log.size() != 16) begin
         errors++;
         $display("FAIL wrr_pop_count: got %0d required 16", pop_log.size());
      end else begin
         for (int i = 0; i < 16; i++) begin
            checks++;
            if (pop_log[i] !== exp_order[i] || pop_cyc[i] !== start + 1 + i) begin
               errors++;
               $display("FAIL wrr_order[%0d]: got VC%0d at cyc %0d required VC%0d at cyc %0d",
                        i, pop_log[i], pop_cyc[i], exp_order[i], start + 1 + i);
            end
         end
      end
      checks++;
      if (sched_state !== 2'd0) begin
         errors++;
         $display("FAIL wrr_final_state: got %0d required 0", sched_state);
      end
   endtask

   task automatic test_back_to_back();
      int ok;
      do_reset();
      vc1_q = '{6'h11, 6'h12, 6'h13, 6'h14, 6'h15};
      step();
      step();
      checks++;
      if (sched_state !== 2'd2) begin
         errors++;
         $display("FAIL b2b_state: got %0d required 2", sched_state);
      end
      for (int i = 0; i < 8; i++) step();
      ok = (pop_log.size() == 5);
      for (int i = 0; ok && i < 5; i++)
         if (pop_log[i] != 1 || pop_cyc[i] != pop_cyc[0] + i) ok = 0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL b2b_pops: got %0d pops required 5 consecutive VC1 pops", pop_log.size());
      end
      checks++;
      if (fwd_count_VC1 !== 8'd5 || fwd_count_VC0 !== 8'd0 || sched_state !== 2'd0) begin
         errors++;
         $display("FAIL b2b_final: cnt1=%0d cnt0=%0d st=%0d required 5 0 0",
                  fwd_count_VC1, fwd_count_VC0, sched_state);
      end
   endtask

   task automatic test_almost_full();
      int c0;
      int vc1_only;
      do_reset();
      af0_r = 1'b1;
      vc0_q = '{6'h01, 6'h02, 6'h03};
      vc1_q = '{6'h12, 6'h13, 6'h14};
      for (int i = 0; i < 8; i++) step();
      vc1_only = (pop_log.size() == 3);
      foreach (pop_log[i]) if (pop_log[i] != 1) vc1_only = 0;
      checks++;
      if (!vc1_only) begin
         errors++;
         $display("FAIL af_blocks_vc0: got %0d pops (vc0 left %0d) required 3 VC1 pops only",
                  pop_log.size(), vc0_q.size());
      end
      af0_r = 1'b0;
      pop_log.delete(); pop_cyc.delete();
      c0 = cyc + 1;
      step();
      step();
      checks++;
      if (pop_log.size() == 0 || pop_log[0] != 0 || pop_cyc[0] > c0 + 1) begin
         errors++;
         $display("FAIL af_release: got %0d pops within 2 cycles required a VC0 pop", pop_log.size());
      end
      drain(20);
   endtask

   task automatic test_init_mid_burst();
      int exp_order[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
      do_reset();
      load_weights(4'd3, 4'd1);
      pop_log.delete(); pop_cyc.delete();
      for (int i = 0; i < 10; i++) begin
         vc0_q.push_back(DW'(i));
         vc1_q.push_back(DW'(6'h20 + i));
      end
      step();
      step();
      init_r = 1'b1;
      step();
      step();
      init_r = 1'b0;
      checks++;
      if (pop_log.size() != 1) begin
         errors++;
         $display("FAIL init_no_pop: got %0d pops required 1 (none during init)", pop_log.size());
      end
      step();
      checks++;
      if (sched_state !== 2'd0 || pop_VC0_fifo !== 1'b0) begin
         errors++;
         $display("FAIL init_idle: st=%0d pop0=%b required 0 0", sched_state, pop_VC0_fifo);
      end
      pop_log.delete(); pop_cyc.delete();
      for (int i = 0; i < 10; i++) step();
      checks++;
      if (pop_log.size() < 8) begin
         errors++;
         $display("FAIL init_resume_count: got %0d pops required >= 8", pop_log.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (pop_log[i] !== exp_order[i]) begin
               errors++;
               $display("FAIL init_resume[%0d]: got VC%0d required VC%0d", i, pop_log[i], exp_order[i]);
            end
         end
      end
      drain(40);
   endtask

   task automatic test_zero_weight_wrap();
      int bad = 0;
      do_reset();
      load_weights(4'd0, 4'd0);
      pop_log.delete(); pop_cyc.delete();
      for (int i = 0; i < 256; i++) begin
         vc0_q.push_back(DW'($urandom_range(0, 63)));
         vc1_q.push_back(DW'($urandom_range(0, 63)));
      end
      drain(700);
      foreach (pop_log[i]) if (pop_log[i] != (i % 2)) bad++;
      checks++;
      if (pop_log.size() != 512 || bad != 0) begin
         errors++;
         $display("FAIL alternation: got %0d pops with %0d out of order required 512 alternating",
                  pop_log.size(), bad);
      end
      checks++;
      if (fwd_count_VC0 !== 8'd0 || fwd_count_VC1 !== 8'd0) begin
         errors++;
         $display("FAIL count_wrap: got %0d/%0d required 0/0", fwd_count_VC0, fwd_count_VC1);
      end
   endtask

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      test_reset();
      test_weighted_rr();
      test_back_to_back();
      test_almost_full();
      test_init_mid_burst();
      test_zero_weight_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
